// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared types for the shift sequencer: operation codes,
//                sequencer state encoding and the legal-opcode helper.
//                The optional carry output (SHIFT_SEQ_CARRY_EN) needs no
//                package content.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_pkg;

  typedef enum logic [2:0] {
    DIR_LSL = 3'd0,
    DIR_LSR = 3'd1,
    DIR_ASR = 3'd2,
    DIR_ROL = 3'd3,
    DIR_ROR = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

  // Codes 5..7 are reserved; they are reported through err.
  function automatic logic dir_legal(input logic [2:0] d);
    return (d <= 3'd4);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer_if
//  Description : Request/response bundle of the shift sequencer.
//                master : requester side (drives request, accepts result)
//                slave  : sequencer side
//  Signals     : in_valid/in_ready/data/shift/direccion  - request channel
//                out_valid/out_ready/resultado/err        - result channel
//                busy                                     - status
//                acarreo (only with SHIFT_SEQ_CARRY_EN)   - last bit out
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_sequencer_if #(
  parameter int N     = 6,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     data;
  logic [AMT_W-1:0] shift;
  logic [2:0]       direccion;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     resultado;
  logic             busy;
  logic             err;
`ifdef SHIFT_SEQ_CARRY_EN
  logic             acarreo;
`endif

  modport master (
    output in_valid, data, shift, direccion, out_ready,
    input  in_ready, out_valid, resultado, busy, err
`ifdef SHIFT_SEQ_CARRY_EN
    , input acarreo
`endif
  );

  modport slave (
    input  in_valid, data, shift, direccion, out_ready,
    output in_ready, out_valid, resultado, busy, err
`ifdef SHIFT_SEQ_CARRY_EN
    , output acarreo
`endif
  );

endinterface
`default_nettype wire

// File: rtl/shift_sequencer_step.sv
`default_nettype none
// ============================================================================
//  Module      : shift_step
//  Description : Combinational narrow shift stage. Moves value by k
//                single-bit positions (k = 0..STEP) in direction dir.
//  Ports       : value  in  N     operand
//                k      in  KW    positions to apply this clock
//                dir    in  dir_e operation
//                result out N     shifted value
//                carry  out 1     last bit pushed out / wrapped
//                                 (present only with SHIFT_SEQ_CARRY_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_pkg::*;
#(
  parameter int N    = 6,
  parameter int STEP = 2,
  parameter int KW   = 2
) (
  input  logic [N-1:0]  value,
  input  logic [KW-1:0] k,
  input  dir_e          dir,
  output logic [N-1:0]  result
`ifdef SHIFT_SEQ_CARRY_EN
  , output logic        carry
`endif
);

  always_comb begin
    logic [N-1:0] v;
`ifdef SHIFT_SEQ_CARRY_EN
    logic c;
    c = 1'b0;
`endif
    v = value;
    // STEP unrolled single-bit stages; stage i is enabled when i < k.
    for (int i = 0; i < STEP; i++) begin
      if (i < int'(k)) begin
`ifdef SHIFT_SEQ_CARRY_EN
        // Leftward ops lose/wrap the msb, rightward ops the lsb.
        c = (dir == DIR_LSL || dir == DIR_ROL) ? v[N-1] : v[0];
`else
        // Carry-free build: only the data path is produced.
`endif
        case (dir)
          DIR_LSL: v = {v[N-2:0], 1'b0};
          DIR_LSR: v = {1'b0, v[N-1:1]};
          DIR_ASR: v = {v[N-1], v[N-1:1]};
          DIR_ROL: v = {v[N-2:0], v[N-1]};
          DIR_ROR: v = {v[0], v[N-1:1]};
          default: v = v;
        endcase
      end
    end
    result = v;
`ifdef SHIFT_SEQ_CARRY_EN
    carry = c;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Multi-cycle shifter. Accepts one request, then applies at
//                most STEP positions per clock through shift_step until the
//                full amount is done, and holds the result until taken.
//                Optional macro SHIFT_SEQ_CARRY_EN adds the acarreo output.
//  Ports       : clk    in  1   clock, rising edge
//                rst_n  in  1   asynchronous active-low reset
//                bus    slave   request/result bundle (shift_sequencer_if)
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int N     = 6,
  parameter int AMT_W = 3,
  parameter int STEP  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_sequencer_if.slave bus
);

  localparam int          c_kw   = $clog2(STEP + 1);
  localparam logic [31:0] c_step = 32'(STEP);

  seq_state_e       r_state;
  logic [N-1:0]     r_work;
  logic [AMT_W-1:0] r_rem;
  dir_e             r_dir;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_err;

  logic             w_last;
  logic [c_kw-1:0]  w_k;
  logic [N-1:0]     w_step_res;

  // The remaining amount fits into one step: this edge finishes the job.
  assign w_last = (32'(r_rem) <= c_step);
  assign w_k    = w_last ? c_kw'(r_rem) : c_kw'(STEP);

`ifdef SHIFT_SEQ_CARRY_EN
  logic r_carry;
  logic w_step_carry;

  shift_step #(.N(N), .STEP(STEP), .KW(c_kw)) u_step (
    .value  (r_work),
    .k      (w_k),
    .dir    (r_dir),
    .result (w_step_res),
    .carry  (w_step_carry)
  );

  assign bus.acarreo = r_carry;
`else
  shift_step #(.N(N), .STEP(STEP), .KW(c_kw)) u_step (
    .value  (r_work),
    .k      (w_k),
    .dir    (r_dir),
    .result (w_step_res)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_work      <= '0;
      r_rem       <= '0;
      r_dir       <= DIR_LSL;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
`ifdef SHIFT_SEQ_CARRY_EN
      r_carry     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            // Accept edge only captures the request; no shifting here.
            r_work     <= bus.data;
            r_rem      <= bus.shift;
            r_dir      <= dir_e'(bus.direccion);
            r_in_ready <= 1'b0;
`ifdef SHIFT_SEQ_CARRY_EN
            r_carry    <= 1'b0;
`endif
            if (bus.shift == '0 || !dir_legal(bus.direccion)) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_err       <= ~dir_legal(bus.direccion);
            end else begin
              r_state <= S_BUSY;
              r_busy  <= 1'b1;
              r_err   <= 1'b0;
            end
          end
        end

        S_BUSY: begin
          r_work <= w_step_res;
          r_rem  <= r_rem - AMT_W'(w_k);
`ifdef SHIFT_SEQ_CARRY_EN
          r_carry <= w_step_carry;
`endif
          if (w_last) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_err       <= 1'b0;
`ifdef SHIFT_SEQ_CARRY_EN
            r_carry     <= 1'b0;
`endif
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_err       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.resultado = r_work;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

endmodule
`default_nettype wire
